// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with 1 start bit, 8 data bits LSB first,
// optional even/odd parity, and 1 or 2 stop bits.
// The line output is registered, so it follows the FSM state by one clock.
module uart_tx #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int PARITY      = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS   = 1    // 1 or 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] symbol_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       uart_txd_in
);

  localparam int BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // baud counter, cycles within one bit
  logic [2:0]       idx_q, idx_d;     // data bit index, reused as stop bit index
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;     // running XOR of bits already sent
  logic             txd_q, line_d;
  logic             bit_end;

  assign bit_end     = (cnt_q == CNT_LAST);
  assign busy_o      = (state_q != S_IDLE);
  assign ready_o     = !busy_o;
  assign uart_txd_in = txd_q;

  // Next-state logic: the baud counter wraps at the end of each bit, which is
  // also the only point where the state changes, so it restarts at every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (valid_i) begin
          state_d = S_START;
          shreg_d = symbol_i;
          par_d   = 1'b0;
          idx_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          par_d   = par_q ^ shreg_q[0];
          if (idx_q == 3'd7) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Line level for the current state; parity uses the bits latched at transfer.
  always_comb begin
    line_d = 1'b1;
    case (state_q)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shreg_q[0];
      S_PARITY: line_d = par_q ^ PAR_ODD;
      default:  line_d = 1'b1;
    endcase
  end

  // State and datapath registers; the pad driver is a flop so it never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= line_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four transmitter instances (no parity, even, odd, two stop bits)
// at 10 clocks per bit, checked cycle by cycle against a frame model and a
// mid-bit sampling receiver model.
module tb_uart_tx;

  localparam int BC = 10;
  localparam int PAR_OF  [4] = '{0, 1, 2, 0};
  localparam int STOP_OF [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] valid;
  logic [7:0] sym [4];
  wire  [3:0] ready_w, busy_w, txd_w;

  int nvec = 0;
  int nerr = 0;
  int samp [$];

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ_HZ(100000000), .BAUD_RATE(10000000), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .symbol_i(sym[0]), .valid_i(valid[0]),
    .ready_o(ready_w[0]), .busy_o(busy_w[0]), .uart_txd_in(txd_w[0]));
  uart_tx #(.CLK_FREQ_HZ(100000000), .BAUD_RATE(10000000), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .symbol_i(sym[1]), .valid_i(valid[1]),
    .ready_o(ready_w[1]), .busy_o(busy_w[1]), .uart_txd_in(txd_w[1]));
  uart_tx #(.CLK_FREQ_HZ(100000000), .BAUD_RATE(10000000), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .symbol_i(sym[2]), .valid_i(valid[2]),
    .ready_o(ready_w[2]), .busy_o(busy_w[2]), .uart_txd_in(txd_w[2]));
  uart_tx #(.CLK_FREQ_HZ(100000000), .BAUD_RATE(10000000), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .symbol_i(sym[3]), .valid_i(valid[3]),
    .ready_o(ready_w[3]), .busy_o(busy_w[3]), .uart_txd_in(txd_w[3]));

  typedef struct {
    int         u;
    logic [7:0] b;
    int         exp_par;   // -1 when the frame carries no parity bit
    int         exp_busy;  // cycles busy_o stays high
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Level of frame slot s (one slot per bit time) for symbol b on instance u.
  function automatic int fbit(input int u, input logic [7:0] b, input int s);
    if (s == 0) return 0;
    if (s >= 1 && s <= 8) return int'(b[s-1]);
    if (PAR_OF[u] != 0 && s == 9) return int'((^b) ^ (PAR_OF[u] == 2));
    return 1;
  endfunction

  function automatic int flen(input int u);
    return (1 + 8 + ((PAR_OF[u] != 0) ? 1 : 0) + STOP_OF[u]) * BC;
  endfunction

  function automatic int sget(input int i);
    if (i < 0 || i >= samp.size()) return 2;
    return samp[i];
  endfunction

  function automatic int find_start(input int from);
    for (int i = from; i < samp.size(); i++)
      if (samp[i] == 0) return i;
    return -1;
  endfunction

  // Receiver model: sample each bit at its centre, starting from the falling edge at s.
  task automatic decode(input int u, input int s, output int db, output int pb, output int ok);
    int np;
    np = (PAR_OF[u] != 0) ? 1 : 0;
    db = 0; pb = -1; ok = (s >= 0) ? 1 : 0;
    if (s < 0) return;
    if (sget(s + BC/2) != 0) ok = 0;
    for (int j = 0; j < 8; j++) begin
      if (sget(s + (1+j)*BC + BC/2) == 1) db = db | (1 << j);
      else if (sget(s + (1+j)*BC + BC/2) != 0) ok = 0;
    end
    if (np != 0) pb = sget(s + 9*BC + BC/2);
    for (int st = 0; st < STOP_OF[u]; st++)
      if (sget(s + (9+np+st)*BC + BC/2) != 1) ok = 0;
  endtask

  // One handshake on instance u, then a cycle-by-cycle check of line/busy/ready
  // against the frame model and a decode of the captured line.
  task automatic run_frame(input int u, input logic [7:0] b, input int exp_par,
                           input int exp_busy, input string nm);
    int n, bcnt, db, pb, ok, el, eb;
    n = flen(u);
    bcnt = 0;
    samp.delete();
    @(negedge clk);
    chk({nm, " ready before"}, int'(ready_w[u]), 1);
    valid[u] = 1'b1; sym[u] = b;
    @(negedge clk);
    valid[u] = 1'b0; sym[u] = ~b;   // later changes must not reach the frame
    for (int k = 0; k <= n + 3; k++) begin
      if (k > 0) @(negedge clk);
      el = (k == 0) ? 1 : fbit(u, b, (k-1)/BC);
      eb = (k < n) ? 1 : 0;
      if (k == 3*BC) sym[u] = 8'h5A;
      samp.push_back(int'(txd_w[u]));
      if (busy_w[u]) bcnt++;
      chk($sformatf("%s line k=%0d", nm, k), int'(txd_w[u]), el);
      chk($sformatf("%s busy k=%0d", nm, k), int'(busy_w[u]), eb);
      chk($sformatf("%s ready k=%0d", nm, k), int'(ready_w[u]), 1 - eb);
    end
    decode(u, find_start(0), db, pb, ok);
    chk({nm, " rx byte"}, db, int'(b));
    chk({nm, " rx parity"}, pb, exp_par);
    chk({nm, " rx framing"}, ok, 1);
    chk({nm, " busy cycles"}, bcnt, exp_busy);
  endtask

  vec_t vt [$];

  initial begin
    int u, db, pb, ok, s, el, eb, idx, f, r;
    logic [7:0] rb;
    logic [7:0] bb [3];

    rst_n = 1'b0;
    valid = '0;
    for (int i = 0; i < 4; i++) sym[i] = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset line u%0d", i), int'(txd_w[i]), 1);
      chk($sformatf("reset ready u%0d", i), int'(ready_w[i]), 1);
      chk($sformatf("reset busy u%0d", i), int'(busy_w[i]), 0);
    end
    rst_n = 1'b1;

    // Directed frames with hand-derived expected parity and busy length.
    vt.push_back('{0, 8'hA5, -1, 100});
    vt.push_back('{1, 8'h07,  1, 110});
    vt.push_back('{2, 8'h07,  0, 110});
    vt.push_back('{1, 8'h00,  0, 110});
    vt.push_back('{3, 8'hFF, -1, 110});
    vt.push_back('{2, 8'h00,  1, 110});
    foreach (vt[i])
      run_frame(vt[i].u, vt[i].b, vt[i].exp_par, vt[i].exp_busy, $sformatf("vec%0d", i));

    // Random frames; expectations come from the parity rule and frame length.
    for (int i = 0; i < 8; i++) begin
      u  = $urandom_range(0, 3);
      rb = 8'($urandom);
      run_frame(u, rb, (PAR_OF[u] == 0) ? -1 : int'((^rb) ^ (PAR_OF[u] == 2)),
                flen(u), $sformatf("rnd%0d", i));
    end

    // Reset pulled low during the start bit.
    @(negedge clk);
    valid[1] = 1'b1; sym[1] = 8'h96;
    @(negedge clk);
    valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("midstart line low", int'(txd_w[1]), 0);
    rst_n = 1'b0;
    #1;
    chk("midstart rst line", int'(txd_w[1]), 1);
    chk("midstart rst ready", int'(ready_w[1]), 1);
    chk("midstart rst busy", int'(busy_w[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back with valid held: 0x01, 0x80, 0x55, symbol_i disturbed mid-frame.
    bb[0] = 8'h01; bb[1] = 8'h80; bb[2] = 8'h55;
    samp.delete();
    @(negedge clk);
    valid[0] = 1'b1; sym[0] = bb[0];
    @(negedge clk);
    for (int k = 0; k <= 3*101 + 15; k++) begin
      if (k > 0) @(negedge clk);
      idx = k - 1;
      f = (idx < 0) ? 3 : idx / 101;
      r = (idx < 0) ? 0 : idx % 101;
      el = (f < 3 && r < 100) ? fbit(0, bb[f], r/10) : 1;
      f = k / 101; r = k % 101;
      eb = (f < 3 && r < 100) ? 1 : 0;
      samp.push_back(int'(txd_w[0]));
      chk($sformatf("b2b line k=%0d", k), int'(txd_w[0]), el);
      chk($sformatf("b2b busy k=%0d", k), int'(busy_w[0]), eb);
      if (k == 20 || k == 121) sym[0] = 8'hEE;
      if (k == 50)  sym[0] = bb[1];
      if (k == 151) sym[0] = bb[2];
      if (k == 222) valid[0] = 1'b0;
    end
    s = 0;
    for (int i = 0; i < 3; i++) begin
      s = find_start(s);
      decode(0, s, db, pb, ok);
      chk($sformatf("b2b rx byte %0d", i), db, int'(bb[i]));
      chk($sformatf("b2b rx framing %0d", i), ok, 1);
      s = (s < 0) ? samp.size() : s + 100;
    end
    chk("b2b no extra frame", find_start(s), -1);

    // Reset during data bit 4 of 0x3C, then a clean 0xC3 frame.
    @(negedge clk);
    valid[0] = 1'b1; sym[0] = 8'h3C;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (55) @(negedge clk);
    chk("bit4 line before reset", int'(txd_w[0]), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("bit4 rst line", int'(txd_w[0]), 1);
    chk("bit4 rst ready", int'(ready_w[0]), 1);
    chk("bit4 rst busy", int'(busy_w[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("recover line idle", int'(txd_w[0]), 1);
    run_frame(0, 8'hC3, -1, 100, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
